// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-facing port of an AHB3-Lite multi-layer switch: decodes, buffers ungranted address phases, steers the data phase.
// Granted path adds no latency; an ungranted transfer holds HREADYOUT low from capture until the slave port accepts it.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SLAVES     = 8
) (
    input  logic                           i_HCLK,
    input  logic                           i_HRESET,
    input  logic [SLAVES*HADDR_SIZE-1:0]   i_slvHADDRbase,
    input  logic [SLAVES*HADDR_SIZE-1:0]   i_slvHADDRmask,
    input  logic                           i_HSEL,
    input  logic [HADDR_SIZE-1:0]          i_HADDR,
    input  logic [HDATA_SIZE-1:0]          i_HWDATA,
    input  logic                           i_HWRITE,
    input  logic [2:0]                     i_HSIZE,
    input  logic [2:0]                     i_HBURST,
    input  logic [3:0]                     i_HPROT,
    input  logic [1:0]                     i_HTRANS,
    input  logic                           i_HMASTLOCK,
    input  logic                           i_HREADY,
    output logic [HDATA_SIZE-1:0]          o_HRDATA,
    output logic                           o_HREADYOUT,
    output logic                           o_HRESP,
    output logic [SLAVES-1:0]              o_slvHSEL,
    output logic [HADDR_SIZE-1:0]          o_slvHADDR,
    output logic [HDATA_SIZE-1:0]          o_slvHWDATA,
    output logic                           o_slvHWRITE,
    output logic [2:0]                     o_slvHSIZE,
    output logic [2:0]                     o_slvHBURST,
    output logic [3:0]                     o_slvHPROT,
    output logic [1:0]                     o_slvHTRANS,
    output logic                           o_slvHMASTLOCK,
    output logic                           o_slvHREADY,
    input  logic [SLAVES*HDATA_SIZE-1:0]   i_slvHRDATA,
    input  logic [SLAVES-1:0]              i_slvHREADYOUT,
    input  logic [SLAVES-1:0]              i_slvHRESP,
    output logic [SLAVES-1:0]              o_can_switch,
    input  logic [SLAVES-1:0]              i_granted
);
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_PEND, ST_ERR1, ST_ERR2} state_t;

    state_t                r_state;
    logic [SW-1:0]         r_dsel;
    logic [SW-1:0]         r_asel;
    logic [HADDR_SIZE-1:0] r_haddr;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [2:0]            r_hburst;
    logic [3:0]            r_hprot;
    logic [1:0]            r_htrans;
    logic                  r_hmastlock;

    logic                  w_hit;
    logic [SW-1:0]         w_idx;
    logic                  w_active;
    logic                  w_d_ready;
    logic                  w_take;
    logic                  w_pend;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if (((i_HADDR ^ i_slvHADDRbase[s*HADDR_SIZE +: HADDR_SIZE]) &
                 i_slvHADDRmask[s*HADDR_SIZE +: HADDR_SIZE]) == '0) begin
                w_hit = 1'b1;
                w_idx = SW'(s);
            end
        end
        w_hit = w_hit & i_HSEL;
    end

    assign w_active  = i_HSEL & i_HREADY & i_HTRANS[1];
    assign w_d_ready = i_slvHREADYOUT[r_dsel];
    assign w_pend    = (r_state == ST_PEND);
    assign w_take    = w_active & ((r_state == ST_IDLE) | (r_state == ST_ERR2) |
                                   ((r_state == ST_DATA) & w_d_ready));

    always_ff @(posedge i_HCLK) begin
        if (i_HRESET) begin
            r_state     <= ST_IDLE;
            r_dsel      <= '0;
            r_asel      <= '0;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_hburst    <= '0;
            r_hprot     <= '0;
            r_htrans    <= '0;
            r_hmastlock <= 1'b0;
        end else begin
            case (r_state)
                ST_PEND: begin
                    if (i_granted[r_asel] && i_slvHREADYOUT[r_asel]) begin
                        r_state <= ST_DATA;
                        r_dsel  <= r_asel;
                    end
                end
                ST_ERR1: r_state <= ST_ERR2;
                default: begin
                    if (w_take) begin
                        if (w_hit && i_granted[w_idx]) begin
                            r_state <= ST_DATA;
                            r_dsel  <= w_idx;
                        end else if (w_hit) begin
                            r_state     <= ST_PEND;
                            r_asel      <= w_idx;
                            r_haddr     <= i_HADDR;
                            r_hwrite    <= i_HWRITE;
                            r_hsize     <= i_HSIZE;
                            r_hburst    <= i_HBURST;
                            r_hprot     <= i_HPROT;
                            r_htrans    <= i_HTRANS;
                            r_hmastlock <= i_HMASTLOCK;
                        end else begin
                            r_state <= ST_ERR1;
                        end
                    end else if (r_state != ST_DATA || w_d_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_slvHSEL      = w_pend ? (SLAVES'(1) << r_asel) :
                            (w_hit ? (SLAVES'(1) << w_idx) : '0);
    assign o_slvHADDR     = w_pend ? r_haddr     : i_HADDR;
    assign o_slvHWRITE    = w_pend ? r_hwrite    : i_HWRITE;
    assign o_slvHSIZE     = w_pend ? r_hsize     : i_HSIZE;
    assign o_slvHBURST    = w_pend ? r_hburst    : i_HBURST;
    assign o_slvHPROT     = w_pend ? r_hprot     : i_HPROT;
    assign o_slvHMASTLOCK = w_pend ? r_hmastlock : i_HMASTLOCK;
    // The slave port never saw the preceding beat, so a replayed SEQ must open as NONSEQ.
    assign o_slvHTRANS    = w_pend ? ((r_htrans == 2'b11) ? 2'b10 : r_htrans) : i_HTRANS;
    assign o_slvHREADY    = w_pend ? i_granted[r_asel] : i_HREADY;
    assign o_slvHWDATA    = i_HWDATA;

    always_comb begin
        o_HRDATA    = '0;
        o_HREADYOUT = 1'b1;
        o_HRESP     = 1'b0;
        case (r_state)
            ST_DATA: begin
                o_HRDATA    = i_slvHRDATA[r_dsel*HDATA_SIZE +: HDATA_SIZE];
                o_HREADYOUT = w_d_ready;
                o_HRESP     = i_slvHRESP[r_dsel];
            end
            ST_PEND: o_HREADYOUT = 1'b0;
            ST_ERR1: begin
                o_HREADYOUT = 1'b0;
                o_HRESP     = 1'b1;
            end
            ST_ERR2: o_HRESP = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        o_can_switch = '1;
        for (int s = 0; s < SLAVES; s++) begin
            if ((w_hit && w_idx == SW'(s) && (i_HTRANS[0] || i_HMASTLOCK)) ||
                (w_pend && r_asel == SW'(s)) ||
                (r_state == ST_DATA && r_dsel == SW'(s) && !i_slvHREADYOUT[s]))
                o_can_switch[s] = 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Bench for the switch master port: directed AHB scenarios with a queue of expected data-phase responses.
module tb_ahb3lite_interconnect_master_port;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 8;
    localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NS*AW-1:0] base, mask;
    logic             hsel, hwrite, hmastlock, hready;
    logic [AW-1:0]    haddr;
    logic [DW-1:0]    hwdata, hrdata;
    logic [2:0]       hsize, hburst;
    logic [3:0]       hprot;
    logic [1:0]       htrans;
    logic             hreadyout, hresp;
    logic [NS-1:0]    s_hsel;
    logic [AW-1:0]    s_haddr;
    logic [DW-1:0]    s_hwdata;
    logic             s_hwrite, s_hmastlock, s_hready;
    logic [2:0]       s_hsize, s_hburst;
    logic [3:0]       s_hprot;
    logic [1:0]       s_htrans;
    logic [NS*DW-1:0] s_hrdata;
    logic [NS-1:0]    s_hreadyout, s_hresp, can_sw, granted;

    assign hready = hreadyout;

    ahb3lite_interconnect_master_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)) dut (
        .i_HCLK(clk), .i_HRESET(rst), .i_slvHADDRbase(base), .i_slvHADDRmask(mask),
        .i_HSEL(hsel), .i_HADDR(haddr), .i_HWDATA(hwdata), .i_HWRITE(hwrite), .i_HSIZE(hsize),
        .i_HBURST(hburst), .i_HPROT(hprot), .i_HTRANS(htrans), .i_HMASTLOCK(hmastlock),
        .i_HREADY(hready), .o_HRDATA(hrdata), .o_HREADYOUT(hreadyout), .o_HRESP(hresp),
        .o_slvHSEL(s_hsel), .o_slvHADDR(s_haddr), .o_slvHWDATA(s_hwdata), .o_slvHWRITE(s_hwrite),
        .o_slvHSIZE(s_hsize), .o_slvHBURST(s_hburst), .o_slvHPROT(s_hprot), .o_slvHTRANS(s_htrans),
        .o_slvHMASTLOCK(s_hmastlock), .o_slvHREADY(s_hready), .i_slvHRDATA(s_hrdata),
        .i_slvHREADYOUT(s_hreadyout), .i_slvHRESP(s_hresp), .o_can_switch(can_sw), .i_granted(granted)
    );

    typedef struct packed {
        logic          resp;
        logic [DW-1:0] rdata;
        logic          chk_rdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   low;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        hsel = 1'b0; htrans = T_IDLE; hmastlock = 1'b0; hwrite = 1'b0; haddr = '0; hburst = '0;
    endtask

    task automatic addr(input logic [AW-1:0] a, input logic [1:0] t, input logic w);
        hsel = 1'b1; haddr = a; htrans = t; hwrite = w; hsize = 3'b010;
    endtask

    function automatic logic [DW-1:0] slv_word(input int s);
        return 32'hC0DE_0000 | DW'(s);
    endfunction

    task automatic test_reset();
        rst = 1'b1; idle_bus(); granted = '0;
        tick(); tick();
        rst = 1'b0;
        smp();
        n_cmp++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL rst_hreadyout got %b want 1", hreadyout); end
        n_cmp++; if (hresp !== 1'b0) begin n_err++; $display("FAIL rst_hresp got %b want 0", hresp); end
        n_cmp++; if (hrdata !== 32'h0) begin n_err++; $display("FAIL rst_hrdata got %h want 0", hrdata); end
        n_cmp++; if (s_hsel !== 8'h00) begin n_err++; $display("FAIL rst_slvhsel got %h want 00", s_hsel); end
        n_cmp++; if (s_htrans !== T_IDLE) begin n_err++; $display("FAIL rst_slvhtrans got %b want 00", s_htrans); end
        n_cmp++; if (s_hready !== 1'b1) begin n_err++; $display("FAIL rst_slvhready got %b want 1", s_hready); end
        n_cmp++; if (can_sw !== 8'hFF) begin n_err++; $display("FAIL rst_can_switch got %h want ff", can_sw); end
    endtask

    task automatic test_granted_write();
        granted = 8'h04;
        tick(); addr(32'h2000_0010, T_NSEQ, 1'b1);
        sb.push_back('{resp: 1'b0, rdata: '0, chk_rdata: 1'b0});
        smp();
        n_cmp++; if (s_hsel !== 8'h04) begin n_err++; $display("FAIL gw_slvhsel got %h want 04", s_hsel); end
        n_cmp++; if (s_haddr !== 32'h2000_0010) begin n_err++; $display("FAIL gw_slvhaddr got %h want 20000010", s_haddr); end
        tick(); idle_bus(); hwdata = 32'hDEAD_BEEF;
        smp();
        n_cmp++; if (s_hwdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL gw_slvhwdata got %h want deadbeef", s_hwdata); end
        n_cmp++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL gw_nowait got %b want 1", hreadyout); end
        e = sb.pop_front();
        n_cmp++; if (hresp !== e.resp) begin n_err++; $display("FAIL gw_hresp got %b want %b", hresp, e.resp); end
    endtask

    task automatic test_ungranted_read();
        granted = 8'h00;
        tick(); addr(32'h2000_0040, T_NSEQ, 1'b0);
        sb.push_back('{resp: 1'b0, rdata: slv_word(2), chk_rdata: 1'b1});
        smp();
        tick(); idle_bus(); haddr = 32'h5555_0000;
        low = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 4) granted = 8'h04;
            smp();
            if (hreadyout) break;
            low++;
            if (c == 0) begin
                n_cmp++; if (s_hsel !== 8'h04) begin n_err++; $display("FAIL ur_slvhsel got %h want 04", s_hsel); end
                n_cmp++; if (s_haddr !== 32'h2000_0040) begin n_err++; $display("FAIL ur_buf_haddr got %h want 20000040", s_haddr); end
                n_cmp++; if (s_htrans !== T_NSEQ) begin n_err++; $display("FAIL ur_slvhtrans got %b want 10", s_htrans); end
                n_cmp++; if (s_hready !== 1'b0) begin n_err++; $display("FAIL ur_slvhready_wait got %b want 0", s_hready); end
            end
            if (c == 4) begin
                n_cmp++; if (s_hready !== 1'b1) begin n_err++; $display("FAIL ur_slvhready_accept got %b want 1", s_hready); end
            end
            tick();
        end
        n_cmp++; if (low !== 5) begin n_err++; $display("FAIL ur_wait_cycles got %0d want 5", low); end
        e = sb.pop_front();
        n_cmp++; if (hrdata !== e.rdata) begin n_err++; $display("FAIL ur_hrdata got %h want %h", hrdata, e.rdata); end
        n_cmp++; if (hresp !== e.resp) begin n_err++; $display("FAIL ur_hresp got %b want %b", hresp, e.resp); end
    endtask

    task automatic test_unmapped();
        granted = 8'hFF;
        tick(); addr(32'hF000_0000, T_NSEQ, 1'b0);
        sb.push_back('{resp: 1'b1, rdata: '0, chk_rdata: 1'b0});
        smp();
        n_cmp++; if (s_hsel !== 8'h00) begin n_err++; $display("FAIL um_slvhsel got %h want 00", s_hsel); end
        tick(); idle_bus();
        smp();
        n_cmp++; if (hreadyout !== 1'b0) begin n_err++; $display("FAIL um_err1_hreadyout got %b want 0", hreadyout); end
        n_cmp++; if (hresp !== 1'b1) begin n_err++; $display("FAIL um_err1_hresp got %b want 1", hresp); end
        tick(); smp();
        e = sb.pop_front();
        n_cmp++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL um_err2_hreadyout got %b want 1", hreadyout); end
        n_cmp++; if (hresp !== e.resp) begin n_err++; $display("FAIL um_err2_hresp got %b want %b", hresp, e.resp); end
        tick(); smp();
        n_cmp++; if (hresp !== 1'b0) begin n_err++; $display("FAIL um_after_hresp got %b want 0", hresp); end
    endtask

    task automatic test_locked_incr4();
        granted = 8'h02;
        tick(); addr(32'h1000_0000, T_NSEQ, 1'b1); hburst = 3'b011; hmastlock = 1'b1;
        smp();
        n_cmp++; if (can_sw !== 8'hFD) begin n_err++; $display("FAIL lk_nseq_can_switch got %h want fd", can_sw); end
        for (int i = 1; i < 4; i++) begin
            tick(); addr(32'h1000_0000 + AW'(4 * i), T_SEQ, 1'b1); hwdata = DW'(i);
            smp();
            n_cmp++; if (can_sw !== 8'hFD) begin n_err++; $display("FAIL lk_seq%0d_can_switch got %h want fd", i, can_sw); end
        end
        tick(); htrans = T_IDLE;
        smp();
        n_cmp++; if (can_sw !== 8'hFD) begin n_err++; $display("FAIL lk_last_can_switch got %h want fd", can_sw); end
        tick(); idle_bus();
        smp();
        n_cmp++; if (can_sw !== 8'hFF) begin n_err++; $display("FAIL lk_done_can_switch got %h want ff", can_sw); end
    endtask

    task automatic test_reset_in_pend();
        granted = 8'h00;
        tick(); addr(32'h3000_0000, T_NSEQ, 1'b0);
        smp();
        tick(); idle_bus();
        smp();
        n_cmp++; if (hreadyout !== 1'b0) begin n_err++; $display("FAIL rp_pend_hreadyout got %b want 0", hreadyout); end
        n_cmp++; if (can_sw !== 8'hF7) begin n_err++; $display("FAIL rp_pend_can_switch got %h want f7", can_sw); end
        tick(); rst = 1'b1;
        smp();
        tick(); rst = 1'b0; granted = 8'h08;
        smp();
        n_cmp++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL rp_hreadyout got %b want 1", hreadyout); end
        n_cmp++; if (s_hsel !== 8'h00) begin n_err++; $display("FAIL rp_slvhsel got %h want 00", s_hsel); end
        n_cmp++; if (can_sw !== 8'hFF) begin n_err++; $display("FAIL rp_can_switch got %h want ff", can_sw); end
        for (int c = 0; c < 3; c++) begin
            tick(); smp();
            n_cmp++; if (s_hsel !== 8'h00 || s_htrans !== T_IDLE) begin n_err++; $display("FAIL rp_replay%0d got hsel %h htrans %b want 00 00", c, s_hsel, s_htrans); end
        end
    endtask

    task automatic test_wait_states();
        granted = 8'h10;
        tick(); addr(32'h4000_0000, T_NSEQ, 1'b0);
        sb.push_back('{resp: 1'b0, rdata: slv_word(4), chk_rdata: 1'b1});
        smp();
        tick(); addr(32'h4000_0100, T_IDLE, 1'b0); s_hreadyout[4] = 1'b0;
        low = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) s_hreadyout[4] = 1'b1;
            smp();
            if (hreadyout) break;
            low++;
            if (c == 0) begin
                n_cmp++; if (can_sw !== 8'hEF) begin n_err++; $display("FAIL ws_can_switch got %h want ef", can_sw); end
            end
            tick();
        end
        s_hreadyout[4] = 1'b1;
        n_cmp++; if (low !== 2) begin n_err++; $display("FAIL ws_wait_cycles got %0d want 2", low); end
        e = sb.pop_front();
        n_cmp++; if (hrdata !== e.rdata) begin n_err++; $display("FAIL ws_hrdata got %h want %h", hrdata, e.rdata); end
        tick(); idle_bus();
        smp();
        n_cmp++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin n_err++; $display("FAIL ws_idle_okay got rdy %b resp %b want 1 0", hreadyout, hresp); end
    endtask

    task automatic test_back_to_back();
        granted = 8'hFF;
        tick(); addr(32'h5000_0000, T_NSEQ, 1'b1);
        sb.push_back('{resp: 1'b0, rdata: '0, chk_rdata: 1'b0});
        smp();
        n_cmp++; if (s_hsel !== 8'h20) begin n_err++; $display("FAIL bb_a_slvhsel got %h want 20", s_hsel); end
        tick(); addr(32'h6000_0000, T_NSEQ, 1'b0); hwdata = 32'hCAFE_F00D;
        sb.push_back('{resp: 1'b0, rdata: slv_word(6), chk_rdata: 1'b1});
        smp();
        n_cmp++; if (s_hsel !== 8'h40) begin n_err++; $display("FAIL bb_b_slvhsel got %h want 40", s_hsel); end
        n_cmp++; if (s_hwdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL bb_a_hwdata got %h want cafef00d", s_hwdata); end
        e = sb.pop_front();
        n_cmp++; if (hreadyout !== 1'b1 || hresp !== e.resp) begin n_err++; $display("FAIL bb_a_resp got rdy %b resp %b want 1 %b", hreadyout, hresp, e.resp); end
        tick(); idle_bus();
        smp();
        e = sb.pop_front();
        n_cmp++; if (hrdata !== e.rdata) begin n_err++; $display("FAIL bb_b_hrdata got %h want %h", hrdata, e.rdata); end
        granted = 8'h00;
        tick(); addr(32'h7000_0008, T_SEQ, 1'b0);
        sb.push_back('{resp: 1'b0, rdata: slv_word(7), chk_rdata: 1'b1});
        smp();
        tick(); idle_bus();
        smp();
        n_cmp++; if (s_htrans !== T_NSEQ) begin n_err++; $display("FAIL bb_seq_replay got %b want 10", s_htrans); end
        n_cmp++; if (s_hsel !== 8'h80) begin n_err++; $display("FAIL bb_seq_slvhsel got %h want 80", s_hsel); end
        tick(); granted = 8'h80;
        smp();
        n_cmp++; if (hreadyout !== 1'b0) begin n_err++; $display("FAIL bb_accept_hreadyout got %b want 0", hreadyout); end
        tick(); smp();
        e = sb.pop_front();
        n_cmp++; if (hreadyout !== 1'b1 || hrdata !== e.rdata) begin n_err++; $display("FAIL bb_seq_data got rdy %b data %h want 1 %h", hreadyout, hrdata, e.rdata); end
        tick(); idle_bus();
    endtask

    initial begin
        for (int s = 0; s < NS; s++) begin
            base[s*AW +: AW]     = AW'(s) << 28;
            mask[s*AW +: AW]     = 32'hF000_0000;
            s_hrdata[s*DW +: DW] = slv_word(s);
        end
        s_hreadyout = '1; s_hresp = '0; granted = '0;
        hwdata = '0; hsize = 3'b010; hprot = 4'b0011;
        idle_bus();
        test_reset();
        test_granted_write();
        test_ungranted_read();
        test_unmapped();
        test_locked_incr4();
        test_reset_in_pend();
        test_wait_states();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
